// File: rtl/mips_test_monitor.sv
// Pass/fail monitor: checks data-memory writes against a table of expected signature writes, with run-cycle timeout.
// Latency: a write sampled on a rising edge of ph1 is reflected in match_mask/pass/fail right after that edge.
// Backpressure: none; purely observes the write port and never stalls the processor.
module mips_test_monitor #(
   parameter int WIDTH = 32,
   parameter int NUM_CHECKS = 4,
   parameter logic [NUM_CHECKS*WIDTH-1:0] CHECK_ADR  = {32'h1C, 32'h18, 32'h14, 32'h10},
   parameter logic [NUM_CHECKS*WIDTH-1:0] CHECK_DATA = {32'hFFFFFFFF, 32'h55, 32'd21, 32'd7},
   parameter bit ORDERED = 1'b0,
   parameter bit STRICT = 1'b1,
   parameter int TIMEOUT = 3000,
   localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
   input  logic                  ph1,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  memwrite,
   input  logic [WIDTH-1:0]      dataadr,
   input  logic [WIDTH-1:0]      writedata,
   output logic [31:0]           cycles,
   output logic [NUM_CHECKS-1:0] match_mask,
   output logic                  done,
   output logic                  pass,
   output logic                  fail,
   output logic [1:0]            fail_code,
   output logic [IW-1:0]         fail_index
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_PASS = 2'b10,
      S_FAIL = 2'b11
   } state_t;

   localparam logic [1:0] CODE_NONE     = 2'b00;
   localparam logic [1:0] CODE_DATA     = 2'b01;
   localparam logic [1:0] CODE_ORDER    = 2'b10;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

   // Cycle value on which the timeout fires; cycles then reads TIMEOUT.
   localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   state_t                state;
   logic [IW-1:0]         next_idx;

   logic                  hit;
   logic [IW-1:0]         hit_idx;
   logic                  data_eq;
   logic                  good_match;
   logic                  wr_fail;
   logic [1:0]            wr_code;
   logic [NUM_CHECKS-1:0] new_mask;
   logic                  all_done;
   logic                  timeout_now;

   // Find the lowest-index unmatched entry whose address equals the write address.
   // Matched entries are skipped so a repeated write never re-triggers a check.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      data_eq = 1'b0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
         if (!hit && !match_mask[i] && (CHECK_ADR[i*WIDTH +: WIDTH] == dataadr)) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
            data_eq = (CHECK_DATA[i*WIDTH +: WIDTH] == writedata);
         end
      end
   end

   // Classify the current write and compute the mask that would result from it.
   always_comb begin
      good_match = memwrite && hit && data_eq && (!ORDERED || (hit_idx == next_idx));
      wr_fail    = memwrite && hit && (data_eq ? (ORDERED && (hit_idx != next_idx)) : STRICT);
      wr_code    = data_eq ? CODE_ORDER : CODE_DATA;
      new_mask   = match_mask;
      for (int i = 0; i < NUM_CHECKS; i++) begin
         if (good_match && (hit_idx == IW'(i))) begin
            new_mask[i] = 1'b1;
         end
      end
      all_done    = &new_mask;
      timeout_now = (TIMEOUT != 0) && (cycles == TO_LAST);
   end

   // Monitor FSM; priority within RUN is write failure, then pass, then timeout.
   always_ff @(posedge ph1) begin
      if (reset) begin
         state      <= S_IDLE;
         cycles     <= 32'd0;
         match_mask <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         fail_code  <= CODE_NONE;
         fail_index <= '0;
         next_idx   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (enable) begin
                  state  <= S_RUN;
                  cycles <= 32'd0;
               end
            end
            S_RUN: begin
               // Count saturates so very long runs never wrap back to a small value.
               if (cycles != 32'hFFFF_FFFF) begin
                  cycles <= cycles + 32'd1;
               end
               if (wr_fail) begin
                  state      <= S_FAIL;
                  done       <= 1'b1;
                  fail       <= 1'b1;
                  fail_code  <= wr_code;
                  fail_index <= hit_idx;
               end else if (good_match && all_done) begin
                  state      <= S_PASS;
                  match_mask <= new_mask;
                  done       <= 1'b1;
                  pass       <= 1'b1;
               end else begin
                  if (good_match) begin
                     match_mask <= new_mask;
                     if (ORDERED) begin
                        next_idx <= next_idx + IW'(1);
                     end
                  end
                  if (timeout_now) begin
                     state      <= S_FAIL;
                     done       <= 1'b1;
                     fail       <= 1'b1;
                     fail_code  <= CODE_TIMEOUT;
                     fail_index <= '0;
                  end
               end
            end
            default: begin
               // PASS and FAIL hold every output until reset.
               state <= state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_test_monitor.sv
// Directed bench for mips_test_monitor: five differently parameterised instances share one stimulus stream.
// Expected outputs are queued as each step is driven and compared one time unit after the following edge.
// Instances: A default, B ordered, C non-strict, D timeout=20, E single entry.
module tb_mips_test_monitor;

   logic        ph1 = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] dataadr = 32'd0;
   logic [31:0] writedata = 32'd0;

   always #5 ph1 = ~ph1;

   typedef struct packed {
      logic [31:0] cyc;
      logic [3:0]  mask;
      logic        done;
      logic        pass;
      logic        fail;
      logic [1:0]  code;
      logic [1:0]  idx;
   } obs_t;

   typedef struct packed {
      logic [2:0] inst;
      obs_t       o;
   } item_t;

   // Per-instance outputs
   logic [31:0] cyc_a, cyc_b, cyc_c, cyc_d, cyc_e;
   logic [3:0]  mask_a, mask_b, mask_c, mask_d;
   logic [0:0]  mask_e;
   logic        done_a, done_b, done_c, done_d, done_e;
   logic        pass_a, pass_b, pass_c, pass_d, pass_e;
   logic        fail_a, fail_b, fail_c, fail_d, fail_e;
   logic [1:0]  code_a, code_b, code_c, code_d, code_e;
   logic [1:0]  idx_a, idx_b, idx_c, idx_d;
   logic [0:0]  idx_e;

   mips_test_monitor u_a (
      .ph1(ph1), .reset(reset), .enable(enable), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .cycles(cyc_a), .match_mask(mask_a),
      .done(done_a), .pass(pass_a), .fail(fail_a), .fail_code(code_a), .fail_index(idx_a)
   );

   mips_test_monitor #(.ORDERED(1'b1)) u_b (
      .ph1(ph1), .reset(reset), .enable(enable), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .cycles(cyc_b), .match_mask(mask_b),
      .done(done_b), .pass(pass_b), .fail(fail_b), .fail_code(code_b), .fail_index(idx_b)
   );

   mips_test_monitor #(.STRICT(1'b0)) u_c (
      .ph1(ph1), .reset(reset), .enable(enable), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .cycles(cyc_c), .match_mask(mask_c),
      .done(done_c), .pass(pass_c), .fail(fail_c), .fail_code(code_c), .fail_index(idx_c)
   );

   mips_test_monitor #(.TIMEOUT(20)) u_d (
      .ph1(ph1), .reset(reset), .enable(enable), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .cycles(cyc_d), .match_mask(mask_d),
      .done(done_d), .pass(pass_d), .fail(fail_d), .fail_code(code_d), .fail_index(idx_d)
   );

   mips_test_monitor #(.NUM_CHECKS(1), .CHECK_ADR(32'h40), .CHECK_DATA(32'hABCD)) u_e (
      .ph1(ph1), .reset(reset), .enable(enable), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .cycles(cyc_e), .match_mask(mask_e),
      .done(done_e), .pass(pass_e), .fail(fail_e), .fail_code(code_e), .fail_index(idx_e)
   );

   obs_t obs [5];
   assign obs[0] = {cyc_a, mask_a, done_a, pass_a, fail_a, code_a, idx_a};
   assign obs[1] = {cyc_b, mask_b, done_b, pass_b, fail_b, code_b, idx_b};
   assign obs[2] = {cyc_c, mask_c, done_c, pass_c, fail_c, code_c, idx_c};
   assign obs[3] = {cyc_d, mask_d, done_d, pass_d, fail_d, code_d, idx_d};
   assign obs[4] = {cyc_e, 3'b000, mask_e, done_e, pass_e, fail_e, code_e, 1'b0, idx_e};

   localparam logic [2:0] IA = 3'd0, IB = 3'd1, IC = 3'd2, ID = 3'd3, IE = 3'd4;

   item_t sbq[$];
   int    n_checks = 0;
   int    n_fails = 0;
   string phase = "init";

   function automatic obs_t mk(input int cyc, input logic [3:0] mask, input logic d,
                               input logic p, input logic f, input logic [1:0] code,
                               input logic [1:0] idx);
      obs_t o;
      o.cyc  = 32'(cyc);
      o.mask = mask;
      o.done = d;
      o.pass = p;
      o.fail = f;
      o.code = code;
      o.idx  = idx;
      return o;
   endfunction

   task automatic expect_obs(input logic [2:0] inst, input obs_t o);
      item_t it;
      it.inst = inst;
      it.o    = o;
      sbq.push_back(it);
   endtask

   // Drive one cycle of stimulus, let the edge happen, then drain the scoreboard.
   task automatic drive(input logic en, input logic mw, input logic [31:0] a, input logic [31:0] d);
      item_t it;
      obs_t  got;
      enable    = en;
      memwrite  = mw;
      dataadr   = a;
      writedata = d;
      @(posedge ph1);
      #1;
      enable   = 1'b0;
      memwrite = 1'b0;
      while (sbq.size() > 0) begin
         it  = sbq.pop_front();
         got = obs[it.inst];
         n_checks++;
         assert (got === it.o) else begin
            n_fails++;
            $error("FAIL %s inst%0d got cyc=%0d mask=%b d/p/f=%b%b%b code=%b idx=%0d exp cyc=%0d mask=%b d/p/f=%b%b%b code=%b idx=%0d",
                   phase, it.inst, got.cyc, got.mask, got.done, got.pass, got.fail, got.code, got.idx,
                   it.o.cyc, it.o.mask, it.o.done, it.o.pass, it.o.fail, it.o.code, it.o.idx);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b0;
   endtask

   obs_t zero;

   initial begin
      zero = mk(0, 4'b0000, 0, 0, 0, 2'b00, 2'd0);

      // Reset state on every build
      phase = "reset";
      reset = 1'b1;
      idle(1);
      for (int i = 0; i < 5; i++) expect_obs(3'(i), zero);
      idle(1);
      reset = 1'b0;

      // IDLE ignores writes
      phase = "idle_ignore";
      expect_obs(IA, zero);
      drive(1'b0, 1'b1, 32'h14, 32'd21);

      // Unordered pass on default build; ordered build fails on the first write
      phase = "enable";
      expect_obs(IA, zero);
      expect_obs(IB, zero);
      drive(1'b1, 1'b0, 32'd0, 32'd0);
      idle(4);
      expect_obs(IA, mk(5, 4'b0000, 0, 0, 0, 2'b00, 2'd0));
      idle(1);
      phase = "unordered_w1";
      expect_obs(IA, mk(6, 4'b0010, 0, 0, 0, 2'b00, 2'd0));
      expect_obs(IB, mk(6, 4'b0000, 1, 0, 1, 2'b10, 2'd1));
      drive(1'b0, 1'b1, 32'h14, 32'd21);
      phase = "unordered_w2";
      expect_obs(IA, mk(7, 4'b0011, 0, 0, 0, 2'b00, 2'd0));
      expect_obs(IB, mk(6, 4'b0000, 1, 0, 1, 2'b10, 2'd1));
      drive(1'b0, 1'b1, 32'h10, 32'd7);
      phase = "unordered_w3";
      expect_obs(IA, mk(8, 4'b1011, 0, 0, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h1C, 32'hFFFF_FFFF);
      phase = "unordered_pass";
      expect_obs(IA, mk(9, 4'b1111, 1, 1, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h18, 32'h55);
      phase = "pass_frozen";
      idle(2);
      expect_obs(IA, mk(9, 4'b1111, 1, 1, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h18, 32'h54);

      // Wrong data: strict build fails, non-strict build ignores it
      phase = "strict";
      do_reset();
      drive(1'b1, 1'b0, 32'd0, 32'd0);
      expect_obs(IA, mk(1, 4'b0000, 1, 0, 1, 2'b01, 2'd2));
      expect_obs(IC, mk(1, 4'b0000, 0, 0, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h18, 32'h54);
      phase = "nonstrict_retry";
      expect_obs(IA, mk(1, 4'b0000, 1, 0, 1, 2'b01, 2'd2));
      expect_obs(IC, mk(2, 4'b0100, 0, 0, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h18, 32'h55);

      // Duplicates, single-entry build, then timeout
      phase = "duplicate";
      do_reset();
      drive(1'b1, 1'b0, 32'd0, 32'd0);
      drive(1'b0, 1'b1, 32'h10, 32'd7);
      expect_obs(ID, mk(2, 4'b0001, 0, 0, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h10, 32'd7);
      expect_obs(IA, mk(3, 4'b0001, 0, 0, 0, 2'b00, 2'd0));
      expect_obs(ID, mk(3, 4'b0001, 0, 0, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h10, 32'd8);
      drive(1'b0, 1'b1, 32'h14, 32'd21);
      drive(1'b0, 1'b1, 32'h18, 32'h55);
      phase = "single_entry";
      expect_obs(IE, mk(6, 4'b0001, 1, 1, 0, 2'b00, 2'd0));
      expect_obs(ID, mk(6, 4'b0111, 0, 0, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h40, 32'hABCD);
      phase = "pre_timeout";
      idle(12);
      expect_obs(ID, mk(19, 4'b0111, 0, 0, 0, 2'b00, 2'd0));
      idle(1);
      phase = "timeout";
      expect_obs(ID, mk(20, 4'b0111, 1, 0, 1, 2'b11, 2'd0));
      idle(1);
      phase = "timeout_frozen";
      expect_obs(ID, mk(20, 4'b0111, 1, 0, 1, 2'b11, 2'd0));
      expect_obs(IE, mk(6, 4'b0001, 1, 1, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h1C, 32'hFFFF_FFFF);

      // Completing match on the timeout edge passes; ordered build passes in order
      phase = "ordered_seq";
      do_reset();
      drive(1'b1, 1'b0, 32'd0, 32'd0);
      expect_obs(IB, mk(1, 4'b0001, 0, 0, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h10, 32'd7);
      expect_obs(IB, mk(2, 4'b0011, 0, 0, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h14, 32'd21);
      expect_obs(IB, mk(3, 4'b0111, 0, 0, 0, 2'b00, 2'd0));
      expect_obs(ID, mk(3, 4'b0111, 0, 0, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h18, 32'h55);
      idle(16);
      phase = "pass_on_timeout_edge";
      expect_obs(ID, mk(20, 4'b1111, 1, 1, 0, 2'b00, 2'd0));
      expect_obs(IB, mk(20, 4'b1111, 1, 1, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h1C, 32'hFFFF_FFFF);

      // Reset in the middle of a run
      phase = "mid_run";
      do_reset();
      drive(1'b1, 1'b0, 32'd0, 32'd0);
      drive(1'b0, 1'b1, 32'h14, 32'd21);
      expect_obs(IA, mk(2, 4'b0011, 0, 0, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h10, 32'd7);
      phase = "mid_run_reset";
      reset = 1'b1;
      expect_obs(IA, zero);
      expect_obs(ID, zero);
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b0;
      phase = "post_reset_ignore";
      expect_obs(IA, zero);
      drive(1'b0, 1'b1, 32'h10, 32'd7);
      expect_obs(IA, zero);
      drive(1'b1, 1'b0, 32'd0, 32'd0);
      phase = "post_reset_run";
      expect_obs(IA, mk(1, 4'b0001, 0, 0, 0, 2'b00, 2'd0));
      drive(1'b0, 1'b1, 32'h10, 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mips_test_monitor.md
Name: mips_test_monitor

Overview:
Synthesizable, parametrised pass/fail monitor for MIPS system-level tests. It watches the processor's data-memory write port and checks a configurable table of expected (address, data) signature writes, either in any order or in strict order. It also tracks elapsed run cycles and flags a timeout. It sits beside the top-level processor in simulation benches and FPGA bring-up builds, replacing ad-hoc single-write checks with a reusable block that reports status.

Parameters:
WIDTH, 32, address/data width
NUM_CHECKS, 4, number of expected signature writes (>=1)
CHECK_ADR, {32'h1C,32'h18,32'h14,32'h10}, flat expected addresses; entry i = CHECK_ADR[i*WIDTH +: WIDTH]
CHECK_DATA, {32'hFFFFFFFF,32'h55,32'd21,32'd7}, flat expected data, same packing
ORDERED, 0, 1 = entries must complete in index order 0..NUM_CHECKS-1
STRICT, 1, 1 = write to a watched address with wrong data is a failure
TIMEOUT, 3000, RUN cycles before failure; 0 disables timeout
IW (localparam), max(1, clog2(NUM_CHECKS)), index width

Ports:
ph1  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  start strobe; sampled only in IDLE
memwrite  in  1  processor data-memory write strobe
dataadr  in  WIDTH  write address
writedata  in  WIDTH  write data
cycles  out  32  RUN cycle count, saturating
match_mask  out  NUM_CHECKS  bit i set once entry i has matched
done  out  1  in PASS or FAIL
pass  out  1  all entries matched
fail  out  1  failure detected
fail_code  out  2  00 none, 01 data mismatch, 10 out of order, 11 timeout
fail_index  out  IW  entry that caused code 01/10; 0 otherwise

Behaviour:
- Reset values: state IDLE; cycles=0, match_mask=0, done=0, pass=0, fail=0, fail_code=00, fail_index=0, next_idx=0.
- Reset has priority over everything. It returns the block to IDLE from any state, including mid-RUN.
- Outputs are registered. A write sampled on edge N shows in match_mask/pass/fail after edge N.
- IDLE: memwrite is ignored. enable=1 moves the block to RUN on the next edge, with cycles=0.
- RUN: cycles increments every edge and saturates at 2^32-1. enable is ignored.
- RUN, on memwrite=1: find the lowest-index entry i not yet matched with CHECK_ADR[i]==dataadr. Already-matched entries are ignored, so rewrites are harmless.
  - data equal, and ORDERED=0 or i==next_idx: set match_mask[i]; in ordered mode increment next_idx.
  - data equal, ORDERED=1, i!=next_idx: FAIL, code 10, fail_index=i.
  - data differs, STRICT=1: FAIL, code 01, fail_index=i.
  - data differs, STRICT=0: no effect.
  - no address hit: no effect.
- When all mask bits would be set after this edge, go to PASS: done=1, pass=1.
- Timeout: when TIMEOUT!=0 and cycles==TIMEOUT-1 on an edge with no pass or fail, go to FAIL with code 11. cycles then reads TIMEOUT, i.e. failure after exactly TIMEOUT RUN cycles.
- Same-edge priority: reset > write failure (01/10) > pass > timeout. A completing match on the timeout edge passes.
- PASS and FAIL are terminal until reset. cycles, match_mask and fail fields are frozen; memwrite is ignored.
- pass and fail are never both 1.

Test Plan:
- Defaults, unordered; enable, then writes (0x14,21),(0x10,7),(0x1C,0xFFFFFFFF),(0x18,0x55) on cycles 5,6,7,8 -> match_mask steps 0010,0011,1011,1111; pass=1, done=1 after edge 8; cycles frozen at 9.
- ORDERED=1; write (0x14,21) first -> fail=1, fail_code=10, fail_index=1, match_mask=0000.
- STRICT=1; write (0x18,0x54) -> fail_code=01, fail_index=2. Rerun with STRICT=0 -> no effect; the later (0x18,0x55) sets bit 2.
- TIMEOUT=20, only 3 entries written -> fail_code=11 after edge 20, cycles=20. Variant: last match on edge 20 -> pass, no fail.
- Reset asserted mid-RUN with mask 0011 -> next edge all outputs 0 and IDLE; writes before a new enable are ignored.
- Duplicate write (0x10,7) twice, then (0x10,8) with STRICT=1 -> no fail, since matched entries are ignored; NUM_CHECKS=1 build -> IW=1, single write passes.
